prbs_checker: RTL and testbench

Serial PRBS checker: the receive end of the pseudorandom bit generator. It consumes the serial bit stream produced by the team's Fibonacci LFSR generator and self-synchronises a local LFSR to it. Once locked, it flags and counts every bit error, and it drops lock on sustained errors. It sits at the loopback or receive side of the PRBS test path and feeds status to the test controller.

---
 rtl/prbs_pkg.sv | 19 +
 rtl/prbs_checker_if.sv | 21 ++
 rtl/prbs_checker_sat_counter.sv | 28 ++
 rtl/prbs_checker.sv | 138 +++++++++++++
 tb/tb_prbs_checker.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker pair: FSM states, default
// polynomial and the common LFSR feedback function.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEED    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } prbs_state_e;

  localparam int         GOOD_RUN     = 8;
  localparam logic [7:0] DEFAULT_POLY = 8'hB8;

  // Feedback / predicted bit; narrower registers are zero-extended by the caller.
  function automatic logic lfsr_fb(input logic [31:0] s, input logic [31:0] poly);
    return ^(s & poly);
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Serial receive stream and status bundle between the PRBS checker and its
// test controller.
interface prbs_checker_if;
  logic        bit_in;
  logic        bit_valid;
  logic        clear_cnt;
  logic        locked;
  logic        err_pulse;
  logic        sync_loss;
  logic [15:0] err_count;

  modport master (
    output bit_in, bit_valid, clear_cnt,
    input  locked, err_pulse, sync_loss, err_count
  );

  modport slave (
    input  bit_in, bit_valid, clear_cnt,
    output locked, err_pulse, sync_loss, err_count
  );
endinterface

// File: rtl/prbs_checker_sat_counter.sv
// 16-bit saturating event counter with synchronous clear taking priority over
// increment.
module sat_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_r;

  // Count register: clear wins, then saturating increment, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= 16'h0000;
    end else if (clr) begin
      count_r <= 16'h0000;
    end else if (inc && (count_r != 16'hFFFF)) begin
      count_r <= count_r + 16'h0001;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: seeds a local LFSR from the stream,
// confirms it over LOCK_CNT bits, then flags/counts errors and drops lock on bursts.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] POLY        = WIDTH'(DEFAULT_POLY),
  parameter int               LOCK_CNT    = 16,
  parameter int               UNLOCK_ERRS = 4
) (
  input logic           clk,
  input logic           reset,
  prbs_checker_if.slave bus
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_ERRS + 1);
  localparam int GOOD_W  = $clog2(GOOD_RUN + 1);

  prbs_state_e        state_r;
  logic [WIDTH-1:0]   s_r;
  logic [FILL_W-1:0]  fill_cnt_r;
  logic [MATCH_W-1:0] match_cnt_r;
  logic [MISS_W-1:0]  miss_cnt_r;
  logic [GOOD_W-1:0]  good_run_r;
  logic               locked_r;
  logic               err_pulse_r;
  logic               sync_loss_r;

  logic               exp_s;
  logic               hit_s;
  logic [WIDTH-1:0]   seed_s;
  logic [WIDTH-1:0]   pred_s;
  logic               err_inc_s;

  assign exp_s     = lfsr_fb(32'(s_r), 32'(POLY));
  assign hit_s     = (bus.bit_in == exp_s);
  assign seed_s    = {s_r[WIDTH-2:0], bus.bit_in};
  // Once seeded, the prediction is shifted in so a bad bit cannot corrupt the register.
  assign pred_s    = {s_r[WIDTH-2:0], exp_s};
  assign err_inc_s = bus.bit_valid && (state_r == LOCKED) && !hit_s;

  // Synchronisation FSM with its fill/match/miss/good-run counters and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= SEED;
      s_r         <= {WIDTH{1'b0}};
      fill_cnt_r  <= {FILL_W{1'b0}};
      match_cnt_r <= {MATCH_W{1'b0}};
      miss_cnt_r  <= {MISS_W{1'b0}};
      good_run_r  <= {GOOD_W{1'b0}};
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
      sync_loss_r <= 1'b0;
    end else begin
      err_pulse_r <= 1'b0;
      sync_loss_r <= 1'b0;
      if (bus.bit_valid) begin
        case (state_r)
          SEED: begin
            s_r <= seed_s;
            if (fill_cnt_r != FILL_W'(WIDTH - 1)) begin
              fill_cnt_r <= fill_cnt_r + FILL_W'(1);
            end else if (seed_s == {WIDTH{1'b0}}) begin
              fill_cnt_r <= {FILL_W{1'b0}};
            end else begin
              fill_cnt_r  <= {FILL_W{1'b0}};
              match_cnt_r <= {MATCH_W{1'b0}};
              state_r     <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            s_r <= pred_s;
            if (!hit_s) begin
              fill_cnt_r  <= {FILL_W{1'b0}};
              match_cnt_r <= {MATCH_W{1'b0}};
              state_r     <= SEED;
            end else if (match_cnt_r == MATCH_W'(LOCK_CNT - 1)) begin
              match_cnt_r <= {MATCH_W{1'b0}};
              miss_cnt_r  <= {MISS_W{1'b0}};
              good_run_r  <= {GOOD_W{1'b0}};
              locked_r    <= 1'b1;
              state_r     <= LOCKED;
            end else begin
              match_cnt_r <= match_cnt_r + MATCH_W'(1);
            end
          end
          LOCKED: begin
            s_r <= pred_s;
            if (!hit_s) begin
              err_pulse_r <= 1'b1;
              good_run_r  <= {GOOD_W{1'b0}};
              if (miss_cnt_r == MISS_W'(UNLOCK_ERRS - 1)) begin
                miss_cnt_r  <= {MISS_W{1'b0}};
                fill_cnt_r  <= {FILL_W{1'b0}};
                match_cnt_r <= {MATCH_W{1'b0}};
                locked_r    <= 1'b0;
                sync_loss_r <= 1'b1;
                state_r     <= SEED;
              end else begin
                miss_cnt_r <= miss_cnt_r + MISS_W'(1);
              end
            end else if (good_run_r == GOOD_W'(GOOD_RUN - 1)) begin
              // A full clean run forgives earlier isolated misses.
              good_run_r <= {GOOD_W{1'b0}};
              miss_cnt_r <= {MISS_W{1'b0}};
            end else begin
              good_run_r <= good_run_r + GOOD_W'(1);
            end
          end
          default: begin
            state_r     <= SEED;
            fill_cnt_r  <= {FILL_W{1'b0}};
            match_cnt_r <= {MATCH_W{1'b0}};
            miss_cnt_r  <= {MISS_W{1'b0}};
            locked_r    <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  sat_counter u_err_count (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clear_cnt),
    .inc   (err_inc_s),
    .count (bus.err_count)
  );

  assign bus.locked    = locked_r;
  assign bus.err_pulse = err_pulse_r;
  assign bus.sync_loss = sync_loss_r;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed and randomized bench for prbs_checker against a bit-history
// reference model of the lock/error rules.
module tb_prbs_checker;

  localparam logic [7:0] TAPS = 8'hB8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  prbs_checker_if bus();

  prbs_checker #(
    .WIDTH       (8),
    .POLY        (8'hB8),
    .LOCK_CNT    (16),
    .UNLOCK_ERRS (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] gen_s;

  // Reference model: mode 0 seeding, 1 confirming, 2 locked.
  int m_mode;
  bit m_hist[$];
  int m_fill, m_match, m_miss, m_good, m_errs;
  bit m_locked, m_pulse, m_loss;
  int pulses, losses;

  task automatic gen_next(output logic b);
    b = ^(gen_s & TAPS);
    gen_s = {gen_s[6:0], b};
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_hist = {};
    repeat (8) m_hist.push_back(1'b0);
    m_fill = 0; m_match = 0; m_miss = 0; m_good = 0; m_errs = 0;
    m_locked = 1'b0; m_pulse = 1'b0; m_loss = 1'b0;
  endtask

  function automatic bit predict();
    logic [7:0] t = TAPS;
    bit e = 1'b0;
    for (int i = 0; i < 8; i++) if (t[i]) e ^= m_hist[7 - i];
    return e;
  endfunction

  task automatic model_step(input bit b, input bit v, input bit c);
    bit e;
    int ones;
    m_pulse = 1'b0;
    m_loss  = 1'b0;
    if (v) begin
      if (m_mode == 0) begin
        m_hist.push_back(b);
        void'(m_hist.pop_front());
        m_fill++;
        if (m_fill == 8) begin
          ones = 0;
          foreach (m_hist[k]) ones += int'(m_hist[k]);
          m_fill = 0;
          if (ones != 0) begin
            m_mode = 1;
            m_match = 0;
          end
        end
      end else begin
        e = predict();
        m_hist.push_back(e);
        void'(m_hist.pop_front());
        if (m_mode == 1) begin
          if (b == e) begin
            m_match++;
            if (m_match == 16) begin
              m_mode = 2; m_locked = 1'b1; m_match = 0; m_miss = 0; m_good = 0;
            end
          end else begin
            m_mode = 0; m_fill = 0; m_match = 0;
          end
        end else if (b != e) begin
          m_pulse = 1'b1;
          if (m_errs < 65535) m_errs++;
          m_miss++;
          m_good = 0;
          if (m_miss == 4) begin
            m_mode = 0; m_loss = 1'b1; m_locked = 1'b0;
            m_fill = 0; m_match = 0; m_miss = 0;
          end
        end else begin
          m_good++;
          if (m_good == 8) begin
            m_good = 0; m_miss = 0;
          end
        end
      end
    end
    if (c) m_errs = 0;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("locked",    int'(bus.locked),    int'(m_locked));
    check("err_pulse", int'(bus.err_pulse), int'(m_pulse));
    check("sync_loss", int'(bus.sync_loss), int'(m_loss));
    check("err_count", int'(bus.err_count), m_errs);
  endtask

  task automatic step(input bit b, input bit v, input bit c);
    bus.bit_in    = b;
    bus.bit_valid = v;
    bus.clear_cnt = c;
    @(posedge clk);
    model_step(b, v, c);
    #1;
    check_all();
    if (bus.err_pulse === 1'b1) pulses++;
    if (bus.sync_loss === 1'b1) losses++;
  endtask

  task automatic send(input bit flip, input bit v, input bit c);
    logic g;
    if (v) begin
      gen_next(g);
      step(g ^ flip, 1'b1, c);
    end else begin
      step(1'($urandom), 1'b0, c);
    end
  endtask

  // Feed the reference stream until locked; n is the number of valid bits used.
  task automatic lock_count(input int maxc, input bit rnd, input int flip_at, output int n);
    bit v;
    n = 0;
    for (int i = 0; i < maxc && bus.locked !== 1'b1; i++) begin
      v = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      if (v) n++;
      send(v && (n == flip_at), v, 1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    int n;
    int lock_hi;
    bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.clear_cnt = 1'b0;
    #2;
    do_reset();

    // Clean stream: lock on the 24th bit, then 1000 bits in total with no errors.
    gen_s = 8'h01;
    lock_count(60, 1'b0, 0, n);
    check("clean_lock_bits", n, 24);
    pulses = 0;
    repeat (976) send(1'b0, 1'b1, 1'b0);
    check("clean_err_count", int'(bus.err_count), 0);
    check("clean_pulses", pulses, 0);
    check("clean_locked", int'(bus.locked), 1);

    // Single error on stream bit 100, then clear.
    do_reset();
    gen_s = 8'h01;
    lock_count(60, 1'b0, 0, n);
    check("single_lock_bits", n, 24);
    pulses = 0;
    repeat (75) send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    check("single_pulse_now", int'(bus.err_pulse), 1);
    repeat (20) send(1'b0, 1'b1, 1'b0);
    check("single_pulses", pulses, 1);
    check("single_count", int'(bus.err_count), 1);
    check("single_locked", int'(bus.locked), 1);
    send(1'b0, 1'b1, 1'b1);
    check("clear_count", int'(bus.err_count), 0);

    // Burst of 4 errors within 6 bits drops lock; clean stream relocks.
    repeat (10) send(1'b0, 1'b1, 1'b0);
    pulses = 0; losses = 0;
    send(1'b1, 1'b1, 1'b0); send(1'b1, 1'b1, 1'b0); send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0); send(1'b0, 1'b1, 1'b0); send(1'b1, 1'b1, 1'b0);
    check("burst_sync_loss_now", int'(bus.sync_loss), 1);
    check("burst_losses", losses, 1);
    check("burst_locked", int'(bus.locked), 0);
    check("burst_count", int'(bus.err_count), 4);
    check("burst_pulses", pulses, 4);
    lock_count(60, 1'b0, 0, n);
    check("burst_relock_bits", n, 24);

    // All-zero input never locks; then a mismatch at bit 12 defers lock to bit 36.
    do_reset();
    lock_hi = 0;
    repeat (200) begin
      step(1'b0, 1'b1, 1'b0);
      if (bus.locked !== 1'b0) lock_hi++;
    end
    check("zero_never_locked", lock_hi, 0);
    lock_count(80, 1'b0, 12, n);
    check("acq_miss_lock_bits", n, 36);

    // Random bit_valid gaps on a clean stream.
    do_reset();
    gen_s = 8'h01;
    lock_count(300, 1'b1, 0, n);
    check("gap_lock_bits", n, 24);
    pulses = 0;
    repeat (200) send(1'b0, 1'($urandom_range(1, 0)), 1'b0);
    check("gap_err_count", int'(bus.err_count), 0);
    check("gap_pulses", pulses, 0);

    // Randomized soak with sparse errors, gaps and clears against the model.
    repeat (800) send(($urandom_range(15, 0) == 0), ($urandom_range(3, 0) != 0),
                      ($urandom_range(39, 0) == 0));

    // Reset while locked with a non-zero error count.
    do_reset();
    gen_s = 8'h01;
    lock_count(60, 1'b0, 0, n);
    send(1'b1, 1'b1, 1'b0);
    repeat (3) send(1'b0, 1'b1, 1'b0);
    check("pre_reset_count", int'(bus.err_count), 1);
    reset = 1'b1;
    #1;
    check("rst_locked", int'(bus.locked), 0);
    check("rst_err_count", int'(bus.err_count), 0);
    check("rst_err_pulse", int'(bus.err_pulse), 0);
    check("rst_sync_loss", int'(bus.sync_loss), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
    lock_count(60, 1'b0, 0, n);
    check("rst_relock_bits", n, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
